dc_access_sched: RTL and testbench

Scheduler sharing the single memory-to-data-cache access register (the 144-bit holding register with busy state, cleared by `dc_done_access`) among `NUM_REQ` flit sources. Selects one valid requester round-robin and issues its flit as a one-cycle `v_m_flits_d` pulse. Holds off further issues until the data cache signals completion or a watchdog expires. Sits between the ring/memory reply queues and the access register, on the data-cache side of the node.

---
 rtl/dc_sched_pkg.sv | 18 +
 rtl/dc_access_sched_rr_arbiter.sv | 46 ++++
 rtl/dc_access_sched.sv | 139 +++++++++++++
 tb/tb_dc_access_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_sched_pkg.sv
// Shared types and constants for the data-cache access scheduler.
package dc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    localparam int FLIT_W_DEF = 144;
    localparam int CNT_W      = 8;
    localparam int IDX_W      = 3;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int n);
        return ((int'(idx) + 1) >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/dc_access_sched_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after i_rr_ptr.
module rr_arbiter
    import dc_sched_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_v_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_win_oh,
    output logic [IDX_W-1:0]   o_win_idx,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
    assign w_dbl = {i_v_req, i_v_req};
    assign w_rot = w_dbl >> i_rr_ptr;

    always_comb begin
        w_off     = '0;
        o_any     = 1'b0;
        o_win_oh  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
                o_any = 1'b1;
            end
        end
        w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
            o_win_idx = IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ));
        end else begin
            o_win_idx = w_sum[IDX_W-1:0];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_any && (IDX_W'(i) == o_win_idx)) begin
                o_win_oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dc_access_sched.sv
// Round-robin scheduler feeding one flit at a time into the data-cache access register.
//   state    | meaning
//   IDLE     | waiting for a valid request while the access register is free
//   ISSUE    | write strobe and requester ack asserted this cycle
//   WAIT     | access outstanding; leave on dc_done_access or watchdog expiry
module dc_access_sched
    import dc_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ*FLIT_W-1:0]   req_flits,
    input  logic [NUM_REQ-1:0]          v_req,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [FLIT_W-1:0]           m_flits_d,
    output logic                        v_m_flits_d,
    input  logic                        m_d_areg_state,
    input  logic                        dc_done_access,
    output logic [IDX_W-1:0]            grant_id,
    output logic [1:0]                  sched_state,
    output logic                        timeout_err
);

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_grant_id;
    logic [CNT_W-1:0]     r_cnt;
    logic [FLIT_W-1:0]    r_m_flits;
    logic                 r_v_m;
    logic [NUM_REQ-1:0]   r_req_ack;
    logic                 r_timeout_err;

    logic [NUM_REQ-1:0]   w_win_oh;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_release;
    logic                 w_timeout;
    logic [FLIT_W-1:0]    w_flit_sel;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_v_req   (v_req),
        .i_rr_ptr  (r_rr_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    always_comb begin
        w_flit_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_flit_sel = req_flits[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && !m_d_areg_state) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over a watchdog expiring in the same cycle.
                if (dc_done_access) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_release   = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_cnt         <= '0;
            r_m_flits     <= '0;
            r_v_m         <= 1'b0;
            r_req_ack     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_v_m     <= w_grant;
            r_req_ack <= w_grant ? w_win_oh : '0;
            if (w_grant) begin
                r_grant_id <= w_win_idx;
                r_m_flits  <= w_flit_sel;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_release) begin
                r_rr_ptr <= next_idx(r_grant_id, NUM_REQ);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign req_ack     = r_req_ack;
    assign m_flits_d   = r_m_flits;
    assign v_m_flits_d = r_v_m;
    assign grant_id    = r_grant_id;
    assign sched_state = r_state;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dc_access_sched.sv
// Table-driven and scoreboard checks for dc_access_sched (3 requesters, TIMEOUT=4).
module tb_dc_access_sched;

    localparam int NREQ = 3;
    localparam int FW   = 144;

    logic              clk;
    logic              rst;
    logic [NREQ*FW-1:0] req_flits;
    logic [NREQ-1:0]   v_req;
    logic [NREQ-1:0]   req_ack;
    logic [FW-1:0]     m_flits_d;
    logic              v_m_flits_d;
    logic              m_d_areg_state;
    logic              dc_done_access;
    logic [2:0]        grant_id;
    logic [1:0]        sched_state;
    logic              timeout_err;

    int n_total = 0;
    int n_bad   = 0;
    int sb[$];
    int cyc = 0;
    int last_strobe = -100;

    dc_access_sched #(.NUM_REQ(NREQ), .FLIT_W(FW), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_flits      (req_flits),
        .v_req          (v_req),
        .req_ack        (req_ack),
        .m_flits_d      (m_flits_d),
        .v_m_flits_d    (v_m_flits_d),
        .m_d_areg_state (m_d_areg_state),
        .dc_done_access (dc_done_access),
        .grant_id       (grant_id),
        .sched_state    (sched_state),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] flit_of(input int i);
        logic [15:0] w;
        w = 16'hC0DE + 16'(i * 16'h1111);
        return {9{w}};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe monitor: pops the expected grant index and checks ack, id, flit and spacing.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (v_m_flits_d === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_strobe: got strobe want none (ack %b)", req_ack);
            end else begin
                int e;
                logic [NREQ-1:0] eoh;
                e = sb.pop_front();
                eoh = NREQ'(1) << e;
                if (req_ack !== eoh || grant_id !== 3'(e) || m_flits_d !== flit_of(e)) begin
                    n_bad++;
                    $display("FAIL sb_grant: got ack=%b id=%0d flit=%h want ack=%b id=%0d flit=%h",
                             req_ack, grant_id, m_flits_d, eoh, e, flit_of(e));
                end
            end
            chk("strobe_spacing_ok", 32'(cyc - last_strobe >= 3), 32'd1);
            last_strobe = cyc;
        end else begin
            chk("ack_idle_zero", 32'(req_ack), 32'd0);
        end
    end

    typedef struct {
        logic [2:0] v;
        logic       busy;
        logic       done;
        logic [1:0] st;
        logic       vm;
        logic [2:0] ack;
        int         idx;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int   nwait;
        bit   found;
        int   rr_exp[4];

        tbl[0]  = '{3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 3'b001, 0};
        tbl[1]  = '{3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 0};
        tbl[2]  = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 0};
        tbl[3]  = '{3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 0};
        tbl[4]  = '{3'b010, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0};
        tbl[5]  = '{3'b010, 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 0};
        tbl[6]  = '{3'b010, 1'b0, 1'b0, 2'd1, 1'b1, 3'b010, 1};
        tbl[7]  = '{3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 0};
        tbl[8]  = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 0};
        tbl[9]  = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 0};
        tbl[10] = '{3'b011, 1'b0, 1'b1, 2'd1, 1'b1, 3'b001, 0};
        tbl[11] = '{3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 0};
        tbl[12] = '{3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 0};
        tbl[13] = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 0};
        tbl[14] = '{3'b011, 1'b0, 1'b0, 2'd1, 1'b1, 3'b010, 1};
        tbl[15] = '{3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000, 0};
        tbl[16] = '{3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 0};
        rr_exp  = '{0, 1, 2, 0};

        req_flits      = {flit_of(2), flit_of(1), flit_of(0)};
        v_req          = '0;
        m_d_areg_state = 1'b0;
        dc_done_access = 1'b0;
        rst            = 1'b0;
        repeat (2) tick();

        chk("rst_state", 32'(sched_state), 32'd0);
        chk("rst_vm", 32'(v_m_flits_d), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_flit_zero", 32'(m_flits_d == '0), 32'd1);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 17; k++) begin
            v_req          = tbl[k].v;
            m_d_areg_state = tbl[k].busy;
            dc_done_access = tbl[k].done;
            if (tbl[k].vm) sb.push_back(tbl[k].idx);
            tick();
            chk($sformatf("tbl%0d_state", k), 32'(sched_state), 32'(tbl[k].st));
            chk($sformatf("tbl%0d_vm", k), 32'(v_m_flits_d), 32'(tbl[k].vm));
            chk($sformatf("tbl%0d_ack", k), 32'(req_ack), 32'(tbl[k].ack));
        end
        dc_done_access = 1'b0;
        m_d_areg_state = 1'b0;

        // Reset in the middle of WAIT with grant_id=2.
        v_req = 3'b100;
        sb.push_back(2);
        tick();
        chk("rstw_issue", 32'(sched_state), 32'd1);
        v_req = '0;
        tick();
        chk("rstw_wait", 32'(sched_state), 32'd2);
        chk("rstw_gid", 32'(grant_id), 32'd2);
        #3;
        rst = 1'b0;
        #1;
        chk("rstw_state0", 32'(sched_state), 32'd0);
        chk("rstw_gid0", 32'(grant_id), 32'd0);
        chk("rstw_flit0", 32'(m_flits_d == '0), 32'd1);
        chk("rstw_vm0", 32'(v_m_flits_d), 32'd0);
        tick();
        rst = 1'b1;
        v_req = 3'b100;
        sb.push_back(2);
        tick();
        chk("post_rst_issue", 32'(sched_state), 32'd1);
        v_req = '0;
        tick();
        dc_done_access = 1'b1;
        tick();
        dc_done_access = 1'b0;
        chk("post_rst_idle", 32'(sched_state), 32'd0);

        // Done lands in the same cycle the watchdog would expire.
        v_req = 3'b001;
        sb.push_back(0);
        tick();
        v_req = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("race_wait%0d", k), 32'(sched_state), 32'd2);
        end
        dc_done_access = 1'b1;
        tick();
        dc_done_access = 1'b0;
        chk("race_idle", 32'(sched_state), 32'd0);
        chk("race_terr0", 32'(timeout_err), 32'd0);

        // Fresh reset, then continuous requests from all three.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        v_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(rr_exp[k]);
            found = 1'b0;
            for (int t = 0; t < 8; t++) begin
                tick();
                if (v_m_flits_d) begin
                    found = 1'b1;
                    break;
                end
            end
            chk($sformatf("rr%0d_strobe_seen", k), 32'(found), 32'd1);
            tick();
            dc_done_access = 1'b1;
            tick();
            dc_done_access = 1'b0;
        end
        v_req = '0;

        // Watchdog: no completion, WAIT must last exactly four cycles.
        v_req = 3'b010;
        sb.push_back(1);
        tick();
        chk("to_issue", 32'(sched_state), 32'd1);
        v_req = '0;
        nwait = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (sched_state == 2'd2) nwait++;
            else break;
        end
        chk("to_wait_len", 32'(nwait), 32'd4);
        chk("to_idle", 32'(sched_state), 32'd0);
        chk("to_terr1", 32'(timeout_err), 32'd1);
        v_req = 3'b011;
        sb.push_back(0);
        tick();
        chk("to_adv_issue", 32'(sched_state), 32'd1);
        v_req = '0;
        tick();
        dc_done_access = 1'b1;
        tick();
        dc_done_access = 1'b0;
        chk("to_terr_sticky", 32'(timeout_err), 32'd1);

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
